scalar_mul_ram_interface: RTL and testbench

- Shared 64-word by 256-bit true dual-port buffer between the host (port A) and the scalar-multiplication datapath (port B).
- Word 0 is a command register, driven out continuously as `command`.
- Word 1 is a status register that mirrors the `status` input from the scalar-multiplication controller.
- Words 2..63 are general storage: curve polynomial at 0x14, private key at 0x15..0x17, and point operands/results.

---
 rtl/scalar_mul_ram_if.sv | 27 ++
 rtl/scalar_mul_ram_interface.sv | 78 +++++++
 tb/tb_scalar_mul_ram_interface.sv | 139 +++++++++++++
 3 files changed

// File: rtl/scalar_mul_ram_if.sv
// Bus bundle for the shared scalar-multiplication buffer: host port A, datapath port B,
// the command word driven out and the controller status word driven in.
interface scalar_mul_ram_if #(
   parameter int Data = 255,
   parameter int Addr = 5
);
   logic          a_w;
   logic [Addr:0] a_adbus;
   logic [Data:0] a_data_in;
   logic [Data:0] a_data_out;
   logic          b_w;
   logic [Addr:0] b_adbus;
   logic [Data:0] b_data_in;
   logic [Data:0] b_data_out;
   logic [Data:0] command;
   logic [Data:0] status;

   modport master (
      output a_w, a_adbus, a_data_in, b_w, b_adbus, b_data_in, status,
      input  a_data_out, b_data_out, command
   );

   modport slave (
      input  a_w, a_adbus, a_data_in, b_w, b_adbus, b_data_in, status,
      output a_data_out, b_data_out, command
   );
endinterface

// File: rtl/scalar_mul_ram_interface.sv
// 64 x 256-bit true dual-port buffer shared by host (A) and scalar-mult datapath (B).
// Word 0 is the command register, word 1 mirrors controller status, words 2..63 are storage.
module scalar_mul_ram_interface #(
   parameter int Data = 255,
   parameter int Addr = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   scalar_mul_ram_if.slave bus
);
   localparam int            Depth      = 1 << (Addr + 1);
   localparam logic [Addr:0] CmdAddr    = '0;
   localparam logic [Addr:0] StatusAddr = (Addr + 1)'(1);

   logic [Data:0] mem [Depth];
   logic [Data:0] cmd_q;
   logic [Data:0] status_q;
   logic [Data:0] a_rd_q;
   logic [Data:0] b_rd_q;
   logic [Data:0] a_rd_word;
   logic [Data:0] b_rd_word;
   logic          a_store_wr;
   logic          b_store_wr;
   logic          b_cmd_wr;
   logic          b_lost;

   // Same-address collision: the host write takes the word, the datapath write is dropped.
   assign b_lost     = bus.a_w && (bus.a_adbus == bus.b_adbus);
   assign a_store_wr = bus.a_w && (bus.a_adbus != CmdAddr) && (bus.a_adbus != StatusAddr);
   assign b_store_wr = bus.b_w && !b_lost
                       && (bus.b_adbus != CmdAddr) && (bus.b_adbus != StatusAddr);
   assign b_cmd_wr   = bus.b_w && (bus.b_adbus == CmdAddr);

   // NOTE: storage words are deliberately left out of reset so the array maps onto RAM macros.
   always_ff @(posedge clk) begin
      if (a_store_wr) mem[bus.a_adbus] <= bus.a_data_in;
      if (b_store_wr) mem[bus.b_adbus] <= bus.b_data_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q    <= '0;
         status_q <= '0;
      end else begin
         status_q <= bus.status;
         if (bus.a_w && (bus.a_adbus == CmdAddr)) cmd_q <= bus.a_data_in;
         else if (b_cmd_wr)                       cmd_q <= bus.b_data_in;
      end
   end

   // NOTE: every branch assigns the read word, so no latch is inferred for unlisted addresses.
   always_comb begin
      a_rd_word = mem[bus.a_adbus];
      if (bus.a_adbus == CmdAddr)         a_rd_word = cmd_q;
      else if (bus.a_adbus == StatusAddr) a_rd_word = status_q;
   end

   always_comb begin
      b_rd_word = mem[bus.b_adbus];
      if (bus.b_adbus == CmdAddr)         b_rd_word = cmd_q;
      else if (bus.b_adbus == StatusAddr) b_rd_word = status_q;
   end

   // Read-first: the read registers sample pre-edge contents alongside any same-edge write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_rd_q <= '0;
         b_rd_q <= '0;
      end else begin
         a_rd_q <= a_rd_word;
         b_rd_q <= b_rd_word;
      end
   end

   assign bus.a_data_out = a_rd_q;
   assign bus.b_data_out = b_rd_q;
   assign bus.command    = cmd_q;
endmodule

// File: tb/tb_scalar_mul_ram_interface.sv
// Directed self-checking bench for scalar_mul_ram_interface with hand-computed expectations.
module tb_scalar_mul_ram_interface;
   localparam int Data = 255;
   localparam int Addr = 5;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_bad;

   scalar_mul_ram_if #(.Data(Data), .Addr(Addr)) bus ();

   scalar_mul_ram_interface #(.Data(Data), .Addr(Addr)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [Data:0] got, input logic [Data:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks     = 0;
      n_bad        = 0;
      rst_n        = 1'b0;
      bus.a_w       = 1'b0;
      bus.a_adbus   = '0;
      bus.a_data_in = '0;
      bus.b_w       = 1'b0;
      bus.b_adbus   = '0;
      bus.b_data_in = '0;
      bus.status    = '0;
      tick();
      tick();
      check("rst_a_out", bus.a_data_out, '0);
      check("rst_b_out", bus.b_data_out, '0);
      check("rst_cmd",   bus.command,    '0);
      rst_n = 1'b1;

      // Word 5 <- 0xAB from A, command <- 0x9 from B on the same edge.
      bus.a_w = 1'b1; bus.a_adbus = 6'd5; bus.a_data_in = 256'hAB;
      bus.b_w = 1'b1; bus.b_adbus = 6'd0; bus.b_data_in = 256'h9;
      tick();
      bus.a_w = 1'b0; bus.b_w = 1'b0;
      tick();
      check("pre_rst_a_out", bus.a_data_out, 256'hAB);
      check("pre_rst_cmd",   bus.command,    256'h9);

      // Asynchronous reset mid-cycle.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_a_out", bus.a_data_out, '0);
      check("async_rst_cmd",   bus.command,    '0);
      tick();
      rst_n = 1'b1;
      tick();
      check("word5_kept", bus.a_data_out, 256'hAB);

      // Polynomial word written by the host, read on both ports.
      bus.a_w = 1'b1; bus.a_adbus = 6'h14; bus.a_data_in = 256'h0000_00A3_0000_0000;
      tick();
      bus.a_w = 1'b0; bus.b_adbus = 6'h14;
      tick();
      check("poly_a", bus.a_data_out, 256'h0000_00A3_0000_0000);
      check("poly_b", bus.b_data_out, 256'h0000_00A3_0000_0000);

      // Command path: host start, then datapath clear; A reads old command on the clear edge.
      bus.a_w = 1'b1; bus.a_adbus = 6'd0; bus.a_data_in = 256'h2;
      tick();
      check("cmd_start", bus.command, 256'h2);
      bus.a_w = 1'b0;
      bus.b_w = 1'b1; bus.b_adbus = 6'd0; bus.b_data_in = '0;
      tick();
      check("cmd_clear", bus.command,    '0);
      check("cmd_rd_old", bus.a_data_out, 256'h2);
      bus.b_w = 1'b0;
      tick();
      check("cmd_rd_new", bus.a_data_out, '0);

      // Same-address collision: A wins.
      bus.a_w = 1'b1; bus.a_adbus = 6'h20; bus.a_data_in = 256'h1111;
      bus.b_w = 1'b1; bus.b_adbus = 6'h20; bus.b_data_in = 256'h2222;
      tick();
      bus.a_w = 1'b0; bus.b_w = 1'b0;
      tick();
      check("coll_a", bus.a_data_out, 256'h1111);
      check("coll_b", bus.b_data_out, 256'h1111);

      // Cross-port read-first.
      bus.a_w = 1'b1; bus.a_adbus = 6'h30; bus.a_data_in = 256'h44;
      tick();
      bus.a_data_in = 256'h55; bus.b_adbus = 6'h30;
      tick();
      check("rf_old", bus.b_data_out, 256'h44);
      bus.a_w = 1'b0;
      tick();
      check("rf_new", bus.b_data_out, 256'h55);

      // Top word written from B, read from A.
      bus.b_w = 1'b1; bus.b_adbus = 6'h3F; bus.b_data_in = {4'hC, 248'h0, 4'h3};
      tick();
      bus.b_w = 1'b0; bus.a_adbus = 6'h3F;
      tick();
      check("top_word", bus.a_data_out, {4'hC, 248'h0, 4'h3});

      // Status mirror: two-cycle lag, writes to address 1 ignored.
      bus.status = 256'h7; bus.a_adbus = 6'd1;
      tick();
      check("stat_lag1", bus.a_data_out, '0);
      tick();
      check("stat_lag2", bus.a_data_out, 256'h7);
      bus.a_w = 1'b1; bus.a_data_in = 256'hFF;
      bus.b_w = 1'b1; bus.b_adbus = 6'd1; bus.b_data_in = 256'hEE;
      tick();
      bus.a_w = 1'b0; bus.b_w = 1'b0;
      tick();
      check("stat_wr_a_ign", bus.a_data_out, 256'h7);
      check("stat_wr_b_ign", bus.b_data_out, 256'h7);
      check("cmd_untouched", bus.command,    '0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end
endmodule
